// File: rtl/riscv_constants.sv
`default_nettype none
// ============================================================================
// Module      : riscv_constants (package)
// Description : Shared encodings for the writeback path. Holds the writeback
//               source select, the register-file write-port grant encoding,
//               auxiliary buffer sizing and a small register helper.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_constants;

    // Pipeline writeback source select
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2
    } wb_sel_e;

    // Owner of the register-file write port in a given cycle
    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_PIPE = 2'd1,
        GRANT_AUX  = 2'd2
    } wb_grant_e;

    // Auxiliary result buffer depth (count register is 2 bits wide)
    localparam logic [1:0] c_AUX_DEPTH = 2'd2;

    // Register-file address width
    localparam int c_REG_ADDR_W = 5;

    // x0 is hard-wired to zero: writes to it are consumed but never issued
    function automatic logic is_x0(input logic [c_REG_ADDR_W-1:0] rd);
        return (rd == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_wb_mux.sv
`default_nettype none
// ============================================================================
// Module      : riscv_wb_mux
// Description : Pipeline writeback source mux. Selects the memory load data,
//               the return address (pc+4) or the ALU result.
// Ports       : wb_sel    - writeback source select
//               alu_out   - ALU result
//               data      - memory load data
//               pc_plus4  - link address
//               wb_data   - selected writeback value
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_wb_mux
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  wb_sel_e                wb_sel,
    input  logic [WORD_LENGTH-1:0] alu_out,
    input  logic [WORD_LENGTH-1:0] data,
    input  logic [WORD_LENGTH-1:0] pc_plus4,
    output logic [WORD_LENGTH-1:0] wb_data
);

    always_comb begin
        wb_data = alu_out;
        case (wb_sel)
            WB_MEM:  wb_data = data;
            WB_PC:   wb_data = pc_plus4;
            default: wb_data = alu_out;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : riscv_wb_arbiter
// Description : Shares the single register-file write port between the
//               in-order pipeline writeback and a long-latency auxiliary
//               unit. Aux results wait in a 2-entry FIFO; the pipeline has
//               priority unless the FIFO is full or its head has waited
//               STARVE_LIMIT cycles, in which case the head is written and
//               the pipeline is stalled.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               a_valid/a_rd/a_wb_sel      - pipeline writeback request
//               a_alu_out/a_data/a_pc_plus4- pipeline candidate results
//               a_stall                    - pipeline must hold WB stage
//               b_valid/b_rd/b_data        - aux result offer
//               b_ready                    - aux buffer can accept
//               rf_we/rf_waddr/rf_wdata    - registered RF write port
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_wb_arbiter
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH  = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a_valid,
    input  logic [4:0]             a_rd,
    input  wb_sel_e                a_wb_sel,
    input  logic [WORD_LENGTH-1:0] a_alu_out,
    input  logic [WORD_LENGTH-1:0] a_data,
    input  logic [WORD_LENGTH-1:0] a_pc_plus4,
    output logic                   a_stall,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [4:0]             b_rd,
    input  logic [WORD_LENGTH-1:0] b_data,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [WORD_LENGTH-1:0] rf_wdata
);

    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    // Aux FIFO state
    logic [4:0]             r_fifo_rd   [0:1];
    logic [WORD_LENGTH-1:0] r_fifo_data [0:1];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;
    logic [c_STARVE_W-1:0]  r_starve;

    // Registered write port
    logic                   r_rf_we;
    logic [4:0]             r_rf_waddr;
    logic [WORD_LENGTH-1:0] r_rf_wdata;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_force;
    logic                   w_push;
    logic                   w_pop;
    wb_grant_e              w_grant;
    logic [WORD_LENGTH-1:0] w_pipe_data;
    logic [4:0]             w_sel_rd;
    logic [WORD_LENGTH-1:0] w_sel_data;

    riscv_wb_mux #(
        .WORD_LENGTH (WORD_LENGTH)
    ) u_wb_mux (
        .wb_sel   (a_wb_sel),
        .alu_out  (a_alu_out),
        .data     (a_data),
        .pc_plus4 (a_pc_plus4),
        .wb_data  (w_pipe_data)
    );

    assign w_empty = (r_count == 2'd0);
    assign w_full  = (r_count == c_AUX_DEPTH);
    assign w_force = w_full || (r_starve == c_STARVE_MAX);

    // Fixed priority: a forced aux grant beats the pipeline, otherwise the
    // pipeline wins and the aux buffer only drains on idle pipeline cycles.
    always_comb begin
        w_grant = GRANT_NONE;
        if (w_force && !w_empty) begin
            w_grant = GRANT_AUX;
        end else if (a_valid) begin
            w_grant = GRANT_PIPE;
        end else if (!w_empty) begin
            w_grant = GRANT_AUX;
        end
    end

    // Only registered state and a_valid feed the stall, never b_valid.
    assign a_stall = w_force && !w_empty && a_valid;
    assign b_ready = !w_full;

    assign w_push = b_valid && b_ready;
    assign w_pop  = (w_grant == GRANT_AUX);

    always_comb begin
        w_sel_rd   = a_rd;
        w_sel_data = w_pipe_data;
        if (w_grant == GRANT_AUX) begin
            w_sel_rd   = r_fifo_rd[r_rd_ptr];
            w_sel_data = r_fifo_data[r_rd_ptr];
        end
    end

    // Storage needs no reset: occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= b_rd;
            r_fifo_data[r_wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_starve <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            // Age of the current head; a pop hands a fresh age to the next head.
            if (w_pop || w_empty) begin
                r_starve <= '0;
            end else if (r_starve != c_STARVE_MAX) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    // Writes to x0 consume the grant but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= (w_grant != GRANT_NONE) && !is_x0(w_sel_rd);
            if ((w_grant != GRANT_NONE) && !is_x0(w_sel_rd)) begin
                r_rf_waddr <= w_sel_rd;
                r_rf_wdata <= w_sel_data;
            end
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

endmodule
`default_nettype wire
